// File: rtl/decim_pkg.sv
// rtl/decim_pkg.sv - shared types and constants for the decimation sequencer
package decim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int OSR_LOG2_MIN = 1;
    localparam int OSR_LOG2_MAX = 10;
    localparam int FCNT_W       = 10;
    localparam int DATA_W_DEF   = 12;

    // Frame length exponent is forced into the range the 10-bit frame counter supports
    function automatic logic [3:0] clamp_osr(input logic [3:0] k);
        logic [3:0] r;
        r = k;
        if (k < 4'(OSR_LOG2_MIN)) begin
            r = 4'(OSR_LOG2_MIN);
        end else if (k > 4'(OSR_LOG2_MAX)) begin
            r = 4'(OSR_LOG2_MAX);
        end
        return r;
    endfunction

endpackage

// File: rtl/decim_sequencer_if.sv
// rtl/decim_sequencer_if.sv - valid/ready readout port of the decimation sequencer
interface decim_sequencer_if
    import decim_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/decim_fifo.sv
// rtl/decim_fifo.sv - small synchronous FIFO with flush and registered head
module decim_fifo
    import decim_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still takes a push
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy; flush discards everything held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/decim_sequencer.sv
// rtl/decim_sequencer.sv - frame timing, settle discard and burst capture for the decimator
module decim_sequencer
    import decim_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_FRAMES = 2,
    parameter int BURST_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         cfg_osr_log2,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               abort,
    input  logic [DATA_W-1:0]  data_in,
    decim_sequencer_if.master  rd,
    output logic               busy,
    output logic               done,
    output logic               overflow
);
    localparam int SCNT_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES + 1) : 1;

    state_t             state;
    state_t             state_nx;
    logic [3:0]         osr_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] bcnt;
    logic [FCNT_W-1:0]  fcnt;
    logic [FCNT_W-1:0]  frame_last;
    logic [SCNT_W-1:0]  scnt;
    logic               start_ok;
    logic               active;
    logic               frame_end;
    logic               settle_last;
    logic               cap;
    logic               burst_last;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    assign frame_last  = FCNT_W'((11'd1 << osr_q) - 11'd1);
    assign start_ok    = start && !abort && (state == ST_IDLE);
    assign active      = (state == ST_SETTLE) || (state == ST_RUN);
    assign frame_end   = active && (fcnt == frame_last);
    assign settle_last = (scnt == SCNT_W'(SETTLE_FRAMES - 1));
    // An aborting cycle captures nothing, even if it lands on a frame end
    assign cap         = (state == ST_RUN) && frame_end && !abort;
    assign burst_last  = (burst_q != '0) && ((bcnt + BURST_W'(1)) == burst_q);
    assign pop         = rd.out_valid && rd.out_ready;
    assign rd.out_valid = !fifo_empty;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and Moore status outputs; abort overrides every transition
    always_comb begin
        state_nx = state;
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        case (state)
            ST_IDLE:   if (start_ok) state_nx = ST_SETTLE;
            ST_SETTLE: if (frame_end && settle_last) state_nx = ST_RUN;
            ST_RUN:    if (cap && burst_last) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
        if (abort) begin
            state_nx = ST_IDLE;
        end
    end

    // Config latches, frame/settle/burst counters and the sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osr_q    <= '0;
            burst_q  <= '0;
            fcnt     <= '0;
            scnt     <= '0;
            bcnt     <= '0;
            overflow <= 1'b0;
        end else if (start_ok) begin
            osr_q    <= clamp_osr(cfg_osr_log2);
            burst_q  <= cfg_burst;
            fcnt     <= '0;
            scnt     <= '0;
            bcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            if (active) begin
                fcnt <= frame_end ? '0 : fcnt + FCNT_W'(1);
            end else begin
                fcnt <= '0;
            end
            if ((state == ST_SETTLE) && frame_end) begin
                scnt <= scnt + SCNT_W'(1);
            end
            if (cap) begin
                bcnt <= bcnt + BURST_W'(1);
            end
            if (cap && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    decim_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (start_ok),
        .push      (cap),
        .pop       (pop),
        .push_data (data_in),
        .rd_data   (rd.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_decim_sequencer.sv
// tb/tb_decim_sequencer.sv - self-checking bench for decim_sequencer
module tb_decim_sequencer;

    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int BW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    cfg_osr_log2 = '0;
    logic [BW-1:0] cfg_burst = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          busy;
    logic          done;
    logic          overflow;

    decim_sequencer_if #(.DATA_W(DW)) rd ();

    decim_sequencer #(
        .DATA_W        (DW),
        .FIFO_DEPTH    (DEPTH),
        .SETTLE_FRAMES (S),
        .BURST_W       (BW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_osr_log2 (cfg_osr_log2),
        .cfg_burst    (cfg_burst),
        .start        (start),
        .abort        (abort),
        .data_in      (data_in),
        .rd           (rd.master),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;

    typedef struct {
        int kraw;
        int burst;
        int ready_pct;
        int pop_at;
        bit cyc_data;
        int exp_first_valid;
        int exp_done;
        int exp_ovf;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp_k(input int k);
        if (k < 1) return 1;
        if (k > 10) return 10;
        return k;
    endfunction

    task automatic run_conv(input int idx, input vec_t v);
        int            f;
        int            dc;
        int            first_v;
        int            seen_done;
        bit            push;
        bit            rdy;
        bit            ev;
        logic [DW-1:0] d;
        f         = 1 << clamp_k(v.kraw);
        dc        = (S + v.burst) * f + 1;
        first_v   = -1;
        seen_done = -1;
        for (int c = 0; c <= dc + 2; c++) begin
            start        = (c == 0) || (c > 0 && c < dc && $urandom_range(7) == 0);
            cfg_osr_log2 = (c == 0) ? 4'(v.kraw) : 4'($urandom_range(15));
            cfg_burst    = (c == 0) ? BW'(v.burst) : BW'($urandom);
            d            = v.cyc_data ? DW'(c) : DW'($urandom);
            data_in      = d;
            rdy          = (v.pop_at >= 0) ? (c == v.pop_at) : ($urandom_range(99) < v.ready_pct);
            rd.out_ready = rdy;
            @(negedge clk);
            ev = (q.size() != 0);
            chk($sformatf("v%0d c%0d out_valid", idx, c), int'(rd.out_valid), int'(ev));
            if (ev) chk($sformatf("v%0d c%0d out_data", idx, c), int'(rd.out_data), int'(q[0]));
            chk($sformatf("v%0d c%0d busy", idx, c), int'(busy), int'(c >= 1 && c <= dc));
            chk($sformatf("v%0d c%0d done", idx, c), int'(done), int'(c == dc));
            chk($sformatf("v%0d c%0d overflow", idx, c), int'(overflow), int'(m_ovf));
            if (c > 0 && rd.out_valid && first_v < 0) first_v = c;
            if (done && seen_done < 0) seen_done = c;
            push = (c >= (S + 1) * f) && (c % f == 0) && (c / f - (S + 1) < v.burst);
            if (c == 0) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (ev && rdy) void'(q.pop_front());
                if (push) begin
                    if (q.size() < DEPTH) q.push_back(d);
                    else m_ovf = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        start        = 1'b0;
        rd.out_ready = 1'b0;
        chk($sformatf("v%0d first_valid_cycle", idx), first_v, v.exp_first_valid);
        chk($sformatf("v%0d done_cycle", idx), seen_done, v.exp_done);
        if (v.exp_ovf >= 0) chk($sformatf("v%0d final_overflow", idx), int'(overflow), v.exp_ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rd.out_ready = 1'b0;
        tbl[0] = '{2, 3, 100, -1, 1'b1, 13, 21, 0};
        tbl[1] = '{3, 6, 0, -1, 1'b0, 25, 65, 1};
        tbl[2] = '{0, 2, 100, -1, 1'b0, 7, 9, 0};
        tbl[3] = '{1, 5, 0, 14, 1'b0, 7, 15, 0};
        tbl[4] = '{15, 1, 70, -1, 1'b0, 3073, 3073, 0};
        tbl[5] = '{1, 9, 100, -1, 1'b0, 7, 23, 0};
        tbl[6] = '{4, 4, 30, -1, 1'b0, 49, 97, -1};

        #1;
        chk("reset out_valid", int'(rd.out_valid), 0);
        chk("reset out_data", int'(rd.out_data), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset overflow", int'(overflow), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_conv(i, tbl[i]);
        end

        // abort during RUN after the first capture (push at 12, abort at 14)
        rd.out_ready = 1'b0;
        for (int c = 0; c <= 30; c++) begin
            start        = (c == 0);
            abort        = (c == 14);
            cfg_osr_log2 = 4'd2;
            cfg_burst    = BW'(5);
            data_in      = DW'(c + 100);
            @(negedge clk);
            if (c == 13) begin
                chk("abort word valid", int'(rd.out_valid), 1);
                chk("abort word data", int'(rd.out_data), 112);
            end
            if (c == 14) chk("abort busy before", int'(busy), 1);
            if (c == 15) chk("abort busy after", int'(busy), 0);
            chk($sformatf("abort c%0d done", c), int'(done), 0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        chk("abort retained valid", int'(rd.out_valid), 1);
        chk("abort retained data", int'(rd.out_data), 112);

        // start and abort together in IDLE: no start, FIFO untouched
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("start_abort c%0d busy", c), int'(busy), 0);
            chk($sformatf("start_abort c%0d out_valid", c), int'(rd.out_valid), 1);
        end
        chk("start_abort out_data", int'(rd.out_data), 112);

        // asynchronous reset in IDLE clears the held word immediately
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("idle_reset out_valid", int'(rd.out_valid), 0);
        chk("idle_reset out_data", int'(rd.out_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_ovf = 1'b0;

        // asynchronous reset in the middle of SETTLE
        cfg_osr_log2 = 4'd3;
        cfg_burst    = BW'(2);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("settle_reset busy before", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("settle_reset busy", int'(busy), 0);
        chk("settle_reset done", int'(done), 0);
        chk("settle_reset overflow", int'(overflow), 0);
        chk("settle_reset out_valid", int'(rd.out_valid), 0);
        chk("settle_reset out_data", int'(rd.out_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk($sformatf("post_reset c%0d busy", c), int'(busy), 0);
            chk($sformatf("post_reset c%0d out_valid", c), int'(rd.out_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
